// File: rtl/experiment_dac_sequencer_if.sv
// experiment_dac_sequencer_if: DMA command stream plus DAC AXI-Stream bundle
interface experiment_dac_sequencer_if #(parameter int NUM_CH = 4);
  logic [15:0]           s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [NUM_CH*256-1:0] m_axis_tdata;
  logic [NUM_CH-1:0]     m_axis_tvalid;
  logic [NUM_CH-1:0]     m_axis_tready;
  modport master (input s_axis_tdata, s_axis_tvalid, m_axis_tready,
                  output s_axis_tready, m_axis_tdata, m_axis_tvalid);
  modport slave (output s_axis_tdata, s_axis_tvalid, m_axis_tready,
                 input s_axis_tready, m_axis_tdata, m_axis_tvalid);
endinterface

// File: rtl/experiment_dac_sequencer.sv
// experiment_dac_sequencer: command-driven frame loader with lockstep DAC replay
// DAC_SEQ_ZERO_IDLE_EN: when defined, tdata is blanked on channels whose tvalid is low
module experiment_dac_sequencer #(parameter int NUM_CH = 4) (
  input  logic                       clk,
  input  logic                       rst,
  experiment_dac_sequencer_if.master bus,
  input  logic                       trig_in,
  output logic                       busy,
  output logic                       err,
  output logic [31:0]                beat_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, SYNC} state_e;
  state_e state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [3:0] ch_q, ch_d;
  logic bad_q, bad_d;
  logic err_q, err_d;
  logic [31:0] beat_q, beat_d;
  logic [NUM_CH-1:0] done_q, done_d, xfer, vld;
  logic [NUM_CH-1:0][255:0] frame_q;
  logic [3:0] op;
  logic acc, beat_done, last;
  assign op = bus.s_axis_tdata[15:12];
  assign acc = bus.s_axis_tvalid & bus.s_axis_tready;
  assign xfer = vld & bus.m_axis_tready;
  assign beat_done = state_q == FIRE && &(done_q | xfer);
  assign last = cnt_q == '0;
  assign err = err_q;
  assign beat_cnt = beat_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc) state_d = op == 4'h1 ? LOAD : op == 4'h2 ? FIRE : op == 4'h3 ? WAIT : op == 4'h4 ? SYNC : IDLE;
      LOAD: if (acc && cnt_q[3:0] == 4'hF) state_d = IDLE;
      FIRE: if (beat_done && last) state_d = IDLE;
      WAIT: if (last) state_d = IDLE;
      SYNC: if (trig_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    vld = state_q == FIRE ? ~done_q : '0;
    busy = state_q != IDLE;
    bus.s_axis_tready = rst && (state_q == IDLE || state_q == LOAD);
    bus.m_axis_tvalid = vld;
    bus.m_axis_tdata = frame_q;
`ifdef DAC_SEQ_ZERO_IDLE_EN
    for (int i = 0; i < NUM_CH; i++) if (!vld[i]) bus.m_axis_tdata[i*256 +: 256] = '0;
`endif
  end
  // cnt_q is the LOAD word index, the FIRE beats remaining, or the WAIT cycles remaining
  always_comb begin
    cnt_d = cnt_q;
    ch_d = ch_q;
    bad_d = bad_q;
    done_d = done_q;
    err_d = err_q;
    beat_d = beat_q + 32'(beat_done);
    if (state_q == IDLE && acc) begin
      cnt_d = op == 4'h1 ? 12'd0 : bus.s_axis_tdata[11:0];
      ch_d = bus.s_axis_tdata[3:0];
      bad_d = 32'(bus.s_axis_tdata[3:0]) >= NUM_CH;
      done_d = '0;
      if (op == 4'hF) begin
        err_d = 1'b0;
        beat_d = '0;
      end
      if ((op == 4'h1 && bad_d) || (op > 4'h4 && op != 4'hF)) err_d = 1'b1;
    end
    if (state_q == LOAD && acc) cnt_d = cnt_q + 12'd1;
    if (state_q == FIRE) begin
      done_d = beat_done ? '0 : done_q | xfer;
      cnt_d = beat_done ? cnt_q - 12'd1 : cnt_q;
    end
    if (state_q == WAIT) cnt_d = cnt_q - 12'd1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      ch_q <= '0;
      bad_q <= 1'b0;
      done_q <= '0;
      err_q <= 1'b0;
      beat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      bad_q <= bad_d;
      done_q <= done_d;
      err_q <= err_d;
      beat_q <= beat_d;
    end
  // out-of-range LOAD targets still consume their 16 words but write nothing
  always_ff @(posedge clk or negedge rst)
    if (!rst) frame_q <= '0;
    else if (state_q == LOAD && acc && !bad_q)
      for (int i = 0; i < NUM_CH; i++)
        if (ch_q == 4'(i)) frame_q[i][{cnt_q[3:0], 4'h0} +: 16] <= bus.s_axis_tdata;
endmodule

// File: doc/experiment_dac_sequencer.md
# experiment_dac_sequencer

Command-driven scheduler for the experiment DAC streams (A, B, C, A NL, ...). Consumes a 16-bit command stream from the CPU DMA, loads one 256-bit frame (16 × 16-bit samples) per DAC channel, and replays those frames on all DAC AXI-Stream masters in lockstep for a programmed beat count. It supports timed waits and external-trigger synchronisation. It sits between the DMA slave port and the DAC master ports of the experiment top level.

## Interface
- `NUM_CH`, default 4: number of DAC channels, range 1..16.
- `clk` input 1: system clock (250 MHz).
- `rst` input 1: asynchronous, active-low reset (0 = reset).
- `s_axis_tdata` input 16: command/data words from DMA.
- `s_axis_tvalid` input 1: DMA word valid.
- `s_axis_tready` output 1: word accepted when tvalid & tready.
- `m_axis_tdata` output NUM_CH*256: channel i occupies bits [256i+255:256i].
- `m_axis_tvalid` output NUM_CH: per-channel valid.
- `m_axis_tready` input NUM_CH: per-channel ready.
- `trig_in` input 1: external trigger, synchronous to clk.
- `busy` output 1: high whenever state ≠ IDLE.
- `err` output 1: sticky error flag.
- `beat_cnt` output 32: completed lockstep beats since reset or CLR; wraps at 2^32.

## Operation
- Header word: opcode = [15:12], arg = [11:0].
- Opcodes:
  - 0x0 NOP.
  - 0x1 LOAD: the next 16 words go to channel arg[3:0]. Word k lands in frame bits [16k+15:16k]. If arg[3:0] ≥ NUM_CH, the 16 words are consumed and discarded, and err is set.
  - 0x2 FIRE: emit arg+1 beats (1..4096).
  - 0x3 WAIT: idle for arg+1 cycles.
  - 0x4 SYNC: wait until trig_in = 1.
  - 0xF CLR: clear err and beat_cnt.
  - Any other opcode: set err; the word is dropped.
- States and transitions:
  - IDLE: accepts a header. Goes to LOAD, FIRE, WAIT or SYNC per opcode; stays in IDLE for NOP, CLR or an illegal opcode.
  - LOAD: 4-bit word counter; returns to IDLE after word 15 is accepted.
  - FIRE: see beat rule below. Returns to IDLE when the last beat completes.
  - WAIT: 12-bit down-counter; returns to IDLE once it expires.
  - SYNC: returns to IDLE in the cycle after trig_in is sampled high.
- `s_axis_tready`:
  - Combinational: 1 in IDLE and LOAD, 0 in FIRE, WAIT and SYNC.
  - Forced to 0 while rst = 0.
- FIRE beat rule (lockstep with per-channel completion):
  - Each channel has a done bit, cleared at the start of each beat.
  - m_axis_tvalid[i] = FIRE & ~done[i].
  - Channel i transfers when tvalid[i] & tready[i]; this sets done[i].
  - A beat completes in the cycle where every channel is done or transferring. All done bits then clear, the beat counter decrements and beat_cnt increments.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Frame registers hold their contents across FIRE, so repeated FIRE commands replay the same frames.
- LOAD is only accepted from IDLE, so a LOAD can never modify a frame during FIRE.
- Reset (asynchronous, at any time, including mid-LOAD or mid-FIRE):
  - State goes to IDLE.
  - All frames, done bits and counters clear to 0.
  - err = 0, beat_cnt = 0, busy = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0.

## Timing
- Header accepted at edge t: busy = 1 from t+1.
- FIRE: m_axis_tvalid goes high at t+1.
- With all tready held at 1, FIRE n emits one beat per cycle, for n+1 consecutive cycles. The state returns to IDLE and s_axis_tready rises in the cycle after the last beat.
- WAIT n: s_axis_tready is low for exactly n+1 cycles after the header edge.
- SYNC: trig_in high at edge t gives IDLE at t+1. If trig_in is already high on entry, the minimum SYNC duration is 1 cycle.
- LOAD is back-to-back capable: 17 words (header + 16 data) in 17 cycles.
- beat_cnt and err are registered and update on the edge after the triggering event.
- CLR takes effect on the edge where it is accepted. If CLR is accepted in the same cycle as an error-setting event, the error wins.

## Configuration
- `DAC_SEQ_ZERO_IDLE_EN`:
  - Defined: m_axis_tdata[i] is driven to 0 whenever m_axis_tvalid[i] = 0.
  - Undefined: m_axis_tdata always presents the frame register, whatever the valid state.
  - Handshake behaviour is identical in both builds.

## Test plan
- Load and fire: LOAD ch0 with words 0x0000..0x000F, then FIRE arg=2 with all tready = 1.
  - Expect 3 consecutive beats; ch0 tdata[15:0] = 0x0000 and [255:240] = 0x000F.
  - beat_cnt ends at 3 and busy returns to 0 one cycle after the last beat.
- Backpressure: FIRE arg=0 with ch1 tready low for 5 cycles and the other channels ready.
  - Expect ch0, ch2 and ch3 tvalid to drop after 1 cycle; ch1 tvalid stays high until ch1 transfers.
  - beat_cnt increments exactly once.
- WAIT and SYNC: WAIT arg=9 gives s_axis_tready low for exactly 10 cycles.
  - SYNC with trig_in asserted 20 cycles later gives tready high one cycle after trig_in.
- Errors:
  - Opcode 0x7 sets err.
  - LOAD arg=5 with NUM_CH=4 consumes 16 words, sets err and leaves all frames unchanged.
  - A following CLR clears err and beat_cnt.
- Mid-FIRE reset: pull rst low during beat 50 of FIRE arg=99.
  - Outputs go to 0 asynchronously.
  - After release, a FIRE arg=0 emits all-zero tdata.
- Macro check: with DAC_SEQ_ZERO_IDLE_EN defined, tdata = 0 between FIRE commands.
  - With it undefined, tdata holds the loaded frame values between FIRE commands.
